seq_cmpl2_to_sm: RTL and testbench

//   Bit-serial decoder from two's complement to sign-magnitude; inverse of the

---
 rtl/seq_cmpl2_to_sm.sv | 95 +++++++++
 tb/tb_seq_cmpl2_to_sm.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_cmpl2_to_sm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_cmpl2_to_sm : bit-serial two's complement -> sign/magnitude decoder
// Revision 1.0
// ---------------------------------------------------------------------------
module seq_cmpl2_to_sm #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] DI,
  output logic [N-1:0] DO,
  output logic         sign,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    r_state;
  logic [N-1:0]  r_sr;
  logic [N-1:0]  r_do;
  logic [CW-1:0] r_cnt;
  logic          r_seen;
  logic          r_sign;
  logic          r_busy;
  logic          r_done;

  logic w_bit;
  logic w_out;

  // Copy bits up to and including the first 1, invert everything above it.
  assign w_bit = r_sr[0];
  assign w_out = (r_sign & r_seen) ? ~w_bit : w_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_do    <= '0;
      r_cnt   <= '0;
      r_seen  <= 1'b0;
      r_sign  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr    <= DI;
            r_sign  <= DI[N-1];
            r_cnt   <= '0;
            r_seen  <= 1'b0;
            r_do    <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_seen <= r_seen | w_bit;
          r_sr   <= r_sr >> 1;
          r_do   <= {w_out, r_do[N-1:1]};
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == C_LAST) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign DO   = r_do;
  assign sign = r_sign;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_cmpl2_to_sm.sv
`default_nettype none
// Directed bench for seq_cmpl2_to_sm: 10-bit instance plus a 4-bit corner instance.
module tb_seq_cmpl2_to_sm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] DI = '0;
  logic [9:0] DO;
  logic       sign, busy, done;

  logic       start4 = 1'b0;
  logic [3:0] DI4 = '0;
  logic [3:0] DO4;
  logic       sign4, busy4, done4;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  seq_cmpl2_to_sm #(.N(10)) u_dut10 (
    .clk(clk), .rst(rst), .start(start), .DI(DI),
    .DO(DO), .sign(sign), .busy(busy), .done(done)
  );

  seq_cmpl2_to_sm #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .DI(DI4),
    .DO(DO4), .sign(sign4), .busy(busy4), .done(done4)
  );

  function automatic logic [10:0] ref10(input logic [9:0] d);
    return {d[9], d[9] ? (~d + 10'd1) : d};
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] d);
    return {d[3], d[3] ? (~d + 4'd1) : d};
  endfunction

  task automatic convert10(input logic [9:0] di, output logic [9:0] do_o,
                           output logic s_o, output int lat, output int bc);
    DI = di; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; DI = ~di;
    lat = 0; bc = 0;
    if (busy) bc++;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bc++;
    end
    do_o = DO; s_o = sign;
    @(posedge clk); #1;
    if (busy) bc++;
  endtask

  task automatic convert4(input logic [3:0] di, output logic [3:0] do_o,
                          output logic s_o, output int lat);
    DI4 = di; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; DI4 = ~di;
    lat = 0;
    while (!done4 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    do_o = DO4; s_o = sign4;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    bit seen;
    vecs++; if ({DO, sign, busy, done} !== 13'd0) begin
      errs++; $display("FAIL reset_state: got %h, want 0", {DO, sign, busy, done});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    DI = 10'h3FB; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vecs++; if (busy !== 1'b1) begin
      errs++; $display("FAIL reset_midshift_busy: got %b, want 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    vecs++; if ({DO, sign, busy, done} !== 13'd0) begin
      errs++; $display("FAIL reset_async_clear: got %h, want 0", {DO, sign, busy, done});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    vecs++; if (seen !== 1'b0) begin
      errs++; $display("FAIL reset_no_done: got done/busy=%b, want 0", seen);
    end
  endtask

  task automatic test_zero;
    logic [9:0] d; logic s; int lat, bc;
    convert10(10'd0, d, s, lat, bc);
    vecs++; if (lat !== 10) begin
      errs++; $display("FAIL zero_latency: got %0d, want 10", lat);
    end
    vecs++; if ({s, d} !== 11'd0) begin
      errs++; $display("FAIL zero_value: got %h, want 0", {s, d});
    end
    vecs++; if (bc !== 11) begin
      errs++; $display("FAIL zero_busy_len: got %0d, want 11", bc);
    end
    vecs++; if ({busy, done} !== 2'b00) begin
      errs++; $display("FAIL zero_idle_after: got %b, want 00", {busy, done});
    end
  endtask

  task automatic test_negative;
    logic [9:0] d; logic s; int lat, bc;
    convert10(10'h3FF, d, s, lat, bc);
    vecs++; if ({s, d} !== {1'b1, 10'd1}) begin
      errs++; $display("FAIL neg_minus1: got %h, want %h", {s, d}, {1'b1, 10'd1});
    end
    convert10(10'h3FB, d, s, lat, bc);
    vecs++; if ({s, d} !== {1'b1, 10'd5}) begin
      errs++; $display("FAIL neg_minus5: got %h, want %h", {s, d}, {1'b1, 10'd5});
    end
  endtask

  task automatic test_extremes;
    logic [9:0] d; logic s; int lat, bc;
    convert10(10'h200, d, s, lat, bc);
    vecs++; if ({s, d} !== {1'b1, 10'h200}) begin
      errs++; $display("FAIL ext_min: got %h, want %h", {s, d}, {1'b1, 10'h200});
    end
    convert10(10'h1FF, d, s, lat, bc);
    vecs++; if ({s, d} !== {1'b0, 10'h1FF}) begin
      errs++; $display("FAIL ext_max: got %h, want %h", {s, d}, {1'b0, 10'h1FF});
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] vals [0:40];
    logic [10:0] exp;
    int ndone;
    for (int j = 0; j <= 40; j++) vals[j] = 10'((j * 397 + 611) % 1024);
    ndone = 0;
    DI = vals[0]; start = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      vecs++; if (done !== (j % 12 == 10)) begin
        errs++; $display("FAIL b2b_done_edge%0d: got %b, want %b", j, done, (j % 12 == 10));
      end
      if (done) begin
        ndone++;
        exp = ref10(vals[j - 10]);
        vecs++; if ({sign, DO} !== exp) begin
          errs++; $display("FAIL b2b_value_edge%0d: got %h, want %h", j, {sign, DO}, exp);
        end
      end
      DI = vals[j + 1];
    end
    start = 1'b0;
    vecs++; if (ndone !== 3) begin
      errs++; $display("FAIL b2b_done_count: got %0d, want 3", ndone);
    end
    // Let the in-flight conversion (accepted at edge 36) drain.
    repeat (14) @(posedge clk);
    #1;
  endtask

  task automatic test_sweep;
    logic [9:0] d; logic s; int lat, bc;
    logic [3:0] d4; logic s4; int lat4;
    logic [3:0] c4 [0:6];
    for (int v = 0; v < 1024; v++) begin
      convert10(10'(v), d, s, lat, bc);
      vecs++; if ({s, d} !== ref10(10'(v)) || lat !== 10) begin
        errs++; $display("FAIL sweep10_%0d: got %h lat %0d, want %h lat 10", v, {s, d}, lat, ref10(10'(v)));
      end
    end
    c4[0] = 4'd0; c4[1] = 4'd1; c4[2] = 4'd7; c4[3] = 4'd8;
    c4[4] = 4'd9; c4[5] = 4'd12; c4[6] = 4'd15;
    for (int k = 0; k < 7; k++) begin
      convert4(c4[k], d4, s4, lat4);
      vecs++; if ({s4, d4} !== ref4(c4[k]) || lat4 !== 4) begin
        errs++; $display("FAIL corner4_%h: got %h lat %0d, want %h lat 4", c4[k], {s4, d4}, lat4, ref4(c4[k]));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_zero;
    test_negative;
    test_extremes;
    test_back_to_back;
    test_sweep;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
